// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults and the sweep FSM state type for the multi-port register file.
// Imported by the top and by the busy scoreboard.
package regfile_mp_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector for RAW hazard detection: issue sets, writeback clears,
// flush clears everything. Also provides the raw busy bit for each read port.
module regfile_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              we,
    input  logic [AW-1:0]     rd,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]    rs_busy_raw
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // NOTE: busy_d is defaulted to busy_q before any conditional update, so no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (flush) begin
                busy_d = '0;
            end else begin
                if (we && rd != '0) begin
                    busy_d[rd] = 1'b0;
                end
                // Applied after the clear so a same-register issue leaves the new producer pending.
                if (iss_valid && iss_rd != '0) begin
                    busy_d[iss_rd] = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only; blocking stays in always_comb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_lookup
        assign rs_busy_raw[i] = busy_q[rs_addr[i*AW +: AW]];
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-read-port integer register file with write-to-read bypass,
// busy scoreboard, and a post-reset zeroing sweep so storage needs no per-entry reset.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                we,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush
);

    rf_state_e        state_q;
    rf_state_e        state_d;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    idx_d;
    logic             run;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [XLEN-1:0]  mem_wdata;
    logic [XLEN-1:0]  mem [NREGS];

    logic [NRD-1:0]   busy_raw;

    assign run   = (state_q == RUN);
    assign ready = run;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == CLEAR) begin
            if (idx_q == AW'(NREGS - 1)) begin
                state_d = RUN;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Single write port shared between the zeroing sweep and writeback.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = rd;
        mem_wdata = wd;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = idx_q;
            mem_wdata = '0;
        end else if (we && rd != '0) begin
            mem_we = 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset so it can map onto RAM; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .we          (we),
        .rd          (rd),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .flush       (flush),
        .rs_addr     (rs_addr),
        .rs_busy_raw (busy_raw)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_read
        logic [AW-1:0] a;
        logic          zero_rd;
        logic          bypass;

        assign a       = rs_addr[i*AW +: AW];
        assign zero_rd = !run || (a == '0);
        assign bypass  = we && (rd == a);

        assign rs_data[i*XLEN +: XLEN] = zero_rd ? '0 : (bypass ? wd : mem[a]);
        assign rs_busy[i]              = !zero_rd && !bypass && busy_raw[i];
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (NREGS=32, XLEN=32, NRD=4): expected reads are
// queued when stimulus is driven and compared against the ports mid-cycle.
module tb_regfile_mp_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int AW    = 5;

    typedef struct {
        string           name;
        int              port;
        logic [XLEN-1:0] data;
        logic            busy;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                ready;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                we;
    logic [AW-1:0]       rd;
    logic [XLEN-1:0]     wd;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                flush;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    regfile_mp_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data),
        .rs_busy   (rs_busy),
        .we        (we),
        .rd        (rd),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_addr(input int a0, input int a1, input int a2, input int a3);
        rs_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic expect_rd(input string name, input int port, input logic [XLEN-1:0] data,
                             input logic busy);
        exp_t e;
        e.name = name;
        e.port = port;
        e.data = data;
        e.busy = busy;
        sb_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        we = 1'b0; rd = '0; wd = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
        set_addr(0, 5, 12, 31);
        repeat (2) next_cycle();
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b, want 0", ready);
        end
        for (int p = 0; p < NRD; p++) expect_rd("reset_read", p, '0, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < NREGS - 1; c++) begin
            @(negedge clk);
            n_vec++;
            if (ready !== 1'b0) begin
                n_err++;
                $display("FAIL sweep_ready cycle %0d: got %b, want 0", c, ready);
            end
            next_cycle();
        end
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL sweep_done_ready: got %b, want 1", ready);
        end
        for (int base = 0; base < NREGS; base += NRD) begin
            set_addr(base, base + 1, base + 2, base + 3);
            for (int p = 0; p < NRD; p++) expect_rd("clear_read", p, '0, 1'b0);
            @(negedge clk);
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_vec++;
                if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                    n_err++;
                    $display("FAIL %s addr %0d: got data=%h busy=%b, want data=%h busy=%b",
                             e.name, base + e.port, rs_data[e.port*XLEN +: XLEN],
                             rs_busy[e.port], e.data, e.busy);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_write_bypass();
        exp_t e;
        we = 1'b1; rd = 5'd5; wd = 32'hDEADBEEF;
        set_addr(5, 0, 6, 5);
        expect_rd("bypass_same_cycle", 0, 32'hDEADBEEF, 1'b0);
        expect_rd("bypass_other_reg", 2, '0, 1'b0);
        expect_rd("bypass_port3", 3, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
        we = 1'b0;
        expect_rd("write_stored", 0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
    endtask

    task automatic test_x0();
        exp_t e;
        we = 1'b1; rd = '0; wd = 32'hFFFFFFFF;
        set_addr(0, 0, 0, 0);
        expect_rd("x0_write_bypass", 0, '0, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
        we = 1'b0;
        iss_valid = 1'b1; iss_rd = '0;
        next_cycle();
        iss_valid = 1'b0;
        expect_rd("x0_after", 0, '0, 1'b0);
        expect_rd("x0_after_p1", 1, '0, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
    endtask

    task automatic test_scoreboard();
        exp_t e;
        set_addr(7, 8, 0, 0);
        iss_valid = 1'b1; iss_rd = 5'd7;
        next_cycle();
        iss_valid = 1'b0;
        expect_rd("issue_busy", 0, '0, 1'b1);
        expect_rd("issue_neighbour", 1, '0, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
        we = 1'b1; rd = 5'd7; wd = 32'h12;
        expect_rd("wb_bypass_unbusy", 0, 32'h12, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
        we = 1'b0;
        expect_rd("wb_cleared", 0, 32'h12, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
        we = 1'b1; rd = 5'd7; wd = 32'h34;
        iss_valid = 1'b1; iss_rd = 5'd7;
        next_cycle();
        we = 1'b0; iss_valid = 1'b0;
        expect_rd("set_wins", 0, 32'h34, 1'b1);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
    endtask

    task automatic test_flush();
        exp_t e;
        iss_valid = 1'b1;
        iss_rd = 5'd3; next_cycle();
        iss_rd = 5'd4; next_cycle();
        iss_rd = 5'd9; next_cycle();
        iss_valid = 1'b0;
        set_addr(3, 4, 9, 7);
        expect_rd("pre_flush_3", 0, '0, 1'b1);
        expect_rd("pre_flush_4", 1, '0, 1'b1);
        expect_rd("pre_flush_9", 2, '0, 1'b1);
        expect_rd("pre_flush_7", 3, 32'h34, 1'b1);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
        flush = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd10;
        we = 1'b1; rd = 5'd3; wd = 32'h33;
        next_cycle();
        flush = 1'b0; iss_valid = 1'b0; we = 1'b0;
        set_addr(3, 4, 9, 10);
        expect_rd("flush_3_written", 0, 32'h33, 1'b0);
        expect_rd("flush_4", 1, '0, 1'b0);
        expect_rd("flush_9", 2, '0, 1'b0);
        expect_rd("flush_beats_issue_10", 3, '0, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
        set_addr(7, 0, 0, 0);
        expect_rd("flush_7", 0, 32'h34, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
    endtask

    task automatic test_nrd4();
        exp_t e;
        we = 1'b1; rd = 5'd1; wd = 32'h11; next_cycle();
        rd = 5'd2; wd = 32'h22; next_cycle();
        we = 1'b0;
        set_addr(1, 2, 1, 0);
        expect_rd("nrd4_p0", 0, 32'h11, 1'b0);
        expect_rd("nrd4_p1", 1, 32'h22, 1'b0);
        expect_rd("nrd4_p2", 2, 32'h11, 1'b0);
        expect_rd("nrd4_p3", 3, '0, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        we = 1'b1; rd = 5'd12; wd = 32'hA5; next_cycle();
        we = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd12; next_cycle();
        iss_valid = 1'b0;
        set_addr(12, 5, 0, 0);
        expect_rd("pre_reset_12", 0, 32'hA5, 1'b1);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
        rst = 1'b1;
        #1;
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_run_ready: got %b, want 0", ready);
        end
        next_cycle();
        rst = 1'b0;
        repeat (5) next_cycle();
        rst = 1'b1;
        #1;
        n_vec++;
        if (ready !== 1'b0 || rs_data[0 +: XLEN] !== '0 || rs_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_sweep: got ready=%b data=%h busy=%b, want 0/0/0", ready,
                     rs_data[0 +: XLEN], rs_busy[0]);
        end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < NREGS - 1; c++) begin
            @(negedge clk);
            n_vec++;
            if (ready !== 1'b0 || rs_data[0 +: XLEN] !== '0 || rs_busy[0] !== 1'b0) begin
                n_err++;
                $display("FAIL resweep cycle %0d: got ready=%b data=%h busy=%b, want 0/0/0",
                         c, ready, rs_data[0 +: XLEN], rs_busy[0]);
            end
            next_cycle();
        end
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL resweep_done_ready: got %b, want 1", ready);
        end
        expect_rd("post_reset_12", 0, '0, 1'b0);
        expect_rd("post_reset_5", 1, '0, 1'b0);
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rs_data[e.port*XLEN +: XLEN] !== e.data || rs_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b", e.name,
                         e.port, rs_data[e.port*XLEN +: XLEN], rs_busy[e.port], e.data, e.busy);
            end
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_x0();
        test_scoreboard();
        test_flush();
        test_nrd4();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the core's single-write/dual-read integer register file.
- Adds configurable data width, register count and read-port count.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard, so the decode stage can detect RAW hazards.
- Adds a post-reset clear sweep, so storage can map to RAM without per-entry reset. Sits between decode (reads, issue) and writeback (write).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of 2, >=2); entry 0 hardwired to zero
NRD, 2, number of combinational read ports
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
ready  out  1  1 when clear sweep done and file usable
rs_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rs_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rs_busy  out  NRD  scoreboard busy flag per read port
we  in  1  writeback write enable
rd  in  AW  writeback address
wd  in  XLEN  writeback data
iss_valid  in  1  issue: mark iss_rd busy
iss_rd  in  AW  issue destination
flush  in  1  clear all busy bits (pipeline flush)

Behaviour:
- Reset (rst=1, async): state=CLEAR, sweep idx=1, busy[all]=0, ready=0. Storage array is not reset.
- CLEAR state:
  - Each cycle writes 0 to reg[idx], then idx++.
  - When idx==NREGS-1 is written, the next state is RUN. ready goes to 1 on the following cycle, exactly NREGS-1 cycles after rst falls.
  - During CLEAR: rs_data=0, rs_busy=0. we, iss_valid and flush are ignored.
- Reset asserted mid-sweep or in RUN restarts CLEAR at idx=1 and clears all busy bits.
- RUN state writes: on edge with we=1 and rd!=0, reg[rd]<=wd. Writes to 0 are ignored.
- Reads, combinational, per port i with a = rs_addr[i]:
  - a==0 -> rs_data=0, rs_busy=0.
  - else if we && rd==a -> rs_data=wd (bypass), rs_busy=0.
  - else -> rs_data=reg[a], rs_busy=busy[a].
- Scoreboard, RUN only, evaluated at the clock edge:
  - we && rd!=0 clears busy[rd].
  - iss_valid && iss_rd!=0 sets busy[iss_rd].
  - If both target the same register in one cycle, set wins (new producer outstanding).
  - flush clears every busy bit. flush has priority over a same-cycle issue, so the flushed issue leaves busy=0. A same-cycle write still updates storage.
- At most one outstanding producer per register. Decode stalls on rs_busy, or on an iss_rd whose busy bit is set. Behaviour beyond that is undefined.
- Read latency 0. Write and scoreboard latency 1 cycle.
- Sweep counter is AW bits and never wraps: it stops in RUN.

Decomposition:
- Shared package (core pkg): XLEN default, NREGS default, and fsm state enum {CLEAR, RUN}.
- One natural sub-module: regfile_scoreboard, containing the busy vector plus set/clear/flush priority logic and the per-port busy lookup.
- Storage, sweep FSM and bypass mux stay in regfile_mp_sb.

Test Plan:
- Clear sweep: NREGS=32. Deassert rst. Expect ready=0 for 31 cycles then ready=1. Read every address; each returns 0x00000000.
- Write and bypass: in RUN, drive we=1, rd=5, wd=0xDEADBEEF with rs_addr port0=5 in the same cycle. Expect rs_data0=0xDEADBEEF combinationally. Next cycle with we=0, still 0xDEADBEEF.
- x0 protection: drive we=1, rd=0, wd=0xFFFFFFFF, then iss_valid=1, iss_rd=0. Reading address 0 gives data 0 and busy 0.
- Scoreboard:
  - Issue iss_rd=7; the next cycle read 7 gives rs_busy=1.
  - Writeback rd=7, wd=0x12: same cycle rs_busy=0 and data 0x12 via bypass. Next cycle busy[7]=0.
  - Simultaneous issue and write to 7 leaves busy[7]=1.
- Flush: set busy on 3, 4 and 9, then pulse flush together with iss_valid=1, iss_rd=10. All four read busy=0 afterwards.
- Reset mid-operation: write 0xA5 to reg 12 and set busy[12], then assert rst at idx=6 of a fresh sweep. Expect ready=0 and busy cleared immediately, then 31 cycles of CLEAR. Reg 12 reads 0.
- NRD=4 configuration: four ports reading 1, 2, 1, 0 after writes 0x11 and 0x22 return 0x11, 0x22, 0x11, 0.
